// File: rtl/xbar_port_arbiter_pkg.sv
// rtl/xbar_port_arbiter_pkg.sv - shared types, defaults and helpers for the crossbar port arbiter
package xbar_port_arbiter_pkg;

  localparam int DEF_N_PORTS   = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_WORDS = 400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/xbar_port_arbiter_rr_picker.sv
// rtl/xbar_port_arbiter_rr_picker.sv - combinational round-robin winner selection
module rr_picker
  import xbar_port_arbiter_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int IDX_W   = (N_PORTS > 1) ? clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [N_PORTS-1:0] winner
);

  logic found;
  int   idx;

  // Scan ports starting just after the previous winner and take the first requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = (int'(last_winner) + k) % N_PORTS;
      if (!found && req[IDX_W'(idx)]) begin
        winner[IDX_W'(idx)] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbar_port_arbiter.sv
// rtl/xbar_port_arbiter.sv - round-robin arbiter muxing N input ports onto one crossbar output
module xbar_port_arbiter
  import xbar_port_arbiter_pkg::*;
#(
  parameter int N_PORTS   = DEF_N_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS-1:0]          iba2xbar_start_pack,
  input  logic [N_PORTS-1:0]          iba2xbar_end_pack,
  input  logic [N_PORTS*DATA_W-1:0]   iba2xbar_data,
  input  logic                        plu_ready,
  output logic [N_PORTS-1:0]          grant,
  output logic [DATA_W-1:0]           xbar2plu_data,
  output logic                        xbar2plu_start_pack,
  output logic                        xbar2plu_end_pack,
  output logic                        err_timeout
);

  localparam int IDX_W = (N_PORTS > 1) ? clog2(N_PORTS) : 1;
  localparam int CNT_W = clog2(MAX_WORDS + 1);

  state_t             state;
  logic [IDX_W-1:0]   last_winner;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   word_cnt;
  logic [N_PORTS-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;

  logic               win_req;
  logic               win_start;
  logic               win_end;
  logic [DATA_W-1:0]  win_data;

  rr_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req         (req),
    .last_winner (last_winner),
    .winner      (pick_onehot)
  );

  // Convert the picker's one-hot winner into a port index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
  end

  // Only the current winner's request, strobes and data are ever looked at.
  always_comb begin
    win_req   = req[win_idx];
    win_start = iba2xbar_start_pack[win_idx];
    win_end   = iba2xbar_end_pack[win_idx];
    win_data  = iba2xbar_data[int'(win_idx)*DATA_W +: DATA_W];
  end

  // Arbitration FSM with registered grant, muxed outputs and word watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= ST_IDLE;
      grant               <= '0;
      last_winner         <= IDX_W'(N_PORTS - 1);
      win_idx             <= '0;
      word_cnt            <= '0;
      xbar2plu_data       <= '0;
      xbar2plu_start_pack <= 1'b0;
      xbar2plu_end_pack   <= 1'b0;
      err_timeout         <= 1'b0;
    end else begin
      xbar2plu_data       <= '0;
      xbar2plu_start_pack <= 1'b0;
      xbar2plu_end_pack   <= 1'b0;
      err_timeout         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((|req) && plu_ready) begin
            grant       <= pick_onehot;
            win_idx     <= pick_idx;
            last_winner <= pick_idx;
            word_cnt    <= '0;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          xbar2plu_data <= win_data;
          if (win_start) begin
            // The first word counts toward the watchdog limit.
            xbar2plu_start_pack <= 1'b1;
            xbar2plu_end_pack   <= win_end;
            word_cnt            <= CNT_W'(1);
            if (win_end) begin
              grant <= '0;
              state <= ST_IDLE;
            end else begin
              state <= ST_XFER;
            end
          end else if (!win_req) begin
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          xbar2plu_data <= win_data;
          word_cnt      <= word_cnt + CNT_W'(1);
          if (win_end) begin
            xbar2plu_end_pack <= 1'b1;
            grant             <= '0;
            state             <= ST_IDLE;
          end else if (word_cnt == CNT_W'(MAX_WORDS - 1)) begin
            // This word is the last one allowed: close the packet ourselves.
            xbar2plu_end_pack <= 1'b1;
            err_timeout       <= 1'b1;
            grant             <= '0;
            state             <= ST_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_port_arbiter.sv
// tb/tb_xbar_port_arbiter.sv - self-checking bench for xbar_port_arbiter
module tb_xbar_port_arbiter;

  localparam int NP   = 4;
  localparam int DW   = 32;
  localparam int MAXW = 8;

  logic           clk;
  logic           reset;
  logic [NP-1:0]  req_r;
  logic [NP-1:0]  start_r;
  logic [NP-1:0]  end_r;
  logic [NP*DW-1:0] data_r;
  logic           plu_ready;
  logic [NP-1:0]  grant;
  logic [DW-1:0]  out_data;
  logic           out_start;
  logic           out_end;
  logic           err_timeout;

  int n_pass;
  int n_total;
  int lw;

  xbar_port_arbiter #(
    .N_PORTS   (NP),
    .DATA_W    (DW),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req                 (req_r),
    .iba2xbar_start_pack (start_r),
    .iba2xbar_end_pack   (end_r),
    .iba2xbar_data       (data_r),
    .plu_ready           (plu_ready),
    .grant               (grant),
    .xbar2plu_data       (out_data),
    .xbar2plu_start_pack (out_start),
    .xbar2plu_end_pack   (out_end),
    .err_timeout         (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Next winner: first requester in the ring, starting after the last winner.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int d = 1; d <= NP; d++) begin
      if (((r >> ((last + d) % NP)) & 4'b0001) != 4'b0000) return (last + d) % NP;
    end
    return -1;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_start"}, out_start, 0);
    chk({tag, "_end"}, out_end, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask

  // Wait for a grant and compare it with the round-robin prediction.
  task automatic wait_grant(output int p);
    int n;
    logic [3:0] oh;
    p = rr_pick(req_r, lw);
    n = 0;
    tick();
    n++;
    while (grant === 4'b0000 && n < 8) begin
      tick();
      n++;
    end
    oh = 4'b0001 << p;
    chk("grant", grant, oh);
    chk("grant_latency", n, 1);
    lw = p;
  endtask

  // Send one packet from granted port p while other ports toggle junk strobes.
  task automatic send_packet(input int p, input int len, input bit with_end,
                             input bit fixed, input logic [31:0] base);
    logic [31:0] d;
    bit last;
    bit forced;
    for (int w = 0; w < len; w++) begin
      d = fixed ? base + 32'(w) : $urandom;
      last = with_end && (w == len - 1);
      for (int q = 0; q < NP; q++) begin
        if (q == p) begin
          start_r[q[1:0]] = (w == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          end_r[q[1:0]]   = last;
          data_r[q*DW +: DW] = d;
        end else begin
          start_r[q[1:0]] = 1'($urandom_range(0, 1));
          end_r[q[1:0]]   = 1'($urandom_range(0, 1));
          data_r[q*DW +: DW] = $urandom;
        end
      end
      tick();
      forced = !with_end && (w + 1 == MAXW);
      chk("out_data", out_data, d);
      chk("out_start", out_start, (w == 0) ? 1 : 0);
      chk("out_end", out_end, (last || forced) ? 1 : 0);
      chk("err_timeout", err_timeout, forced ? 1 : 0);
      if (last || forced) begin
        chk("grant_released", grant, 0);
        break;
      end
    end
    start_r = '0;
    end_r   = '0;
    data_r  = '0;
  endtask

  initial begin
    int p;
    int len;
    logic [3:0] oh;
    n_pass    = 0;
    n_total   = 0;
    lw        = NP - 1;
    reset     = 1'b0;
    req_r     = '0;
    start_r   = '0;
    end_r     = '0;
    data_r    = '0;
    plu_ready = 1'b1;

    // Reset and quiet idle.
    tick();
    tick();
    chk_idle_outputs("in_reset");
    reset = 1'b1;
    tick();
    tick();
    chk_idle_outputs("after_reset");

    // All ports requesting, 3-word packets: order 0,1,2,3,0; first packet has fixed data.
    req_r = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(p);
      chk("rr_order", p, k % NP);
      send_packet(p, 3, 1'b1, (k == 0), 32'hA5A5_0001);
    end

    // Single-word packet on port 2.
    req_r = 4'b0100;
    wait_grant(p);
    chk("single_port", p, 2);
    send_packet(p, 1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    req_r = 4'b0000;
    tick();
    chk("single_released", grant, 0);

    // Downstream not ready holds off the grant.
    plu_ready = 1'b0;
    req_r = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("not_ready_hold", grant, 0);
    end
    plu_ready = 1'b1;
    wait_grant(p);
    // Aborted grant: request withdrawn before the start strobe.
    req_r = 4'b0000;
    tick();
    chk("abort_grant", grant, 0);
    chk("abort_start", out_start, 0);
    req_r = 4'b1111;
    wait_grant(p);
    chk("after_abort_next", p, 1);
    send_packet(p, 2, 1'b1, 1'b0, 32'h0);

    // Watchdog: port 1 streams 12 words with no end strobe, port 3 also waiting.
    req_r = 4'b0010;
    wait_grant(p);
    chk("wd_port", p, 1);
    req_r = 4'b1010;
    send_packet(p, 12, 1'b0, 1'b0, 32'h0);
    for (int w = 8; w < 12; w++) begin
      start_r[1] = 1'($urandom_range(0, 1));
      end_r[1]   = (w == 11);
      data_r[1*DW +: DW] = $urandom;
      tick();
      if (w == 8) begin
        oh = 4'b1000;
        chk("wd_next_grant", grant, oh);
        lw = 3;
      end
      chk("wd_ignored_start", out_start, 0);
      chk("wd_ignored_end", out_end, 0);
      chk("wd_err_once", err_timeout, 0);
    end
    start_r = '0;
    end_r   = '0;
    req_r   = 4'b1000;
    send_packet(3, 2, 1'b1, 1'b0, 32'h0);

    // Randomised traffic against the round-robin model.
    for (int k = 0; k < 25; k++) begin
      req_r = req_r | 4'($urandom_range(1, 15));
      wait_grant(p);
      if ($urandom_range(0, 7) == 0) begin
        req_r[p[1:0]] = 1'b0;
        tick();
        chk("rand_abort", grant, 0);
      end else begin
        len = $urandom_range(1, MAXW + 3);
        send_packet(p, len, (len < MAXW) ? 1'b1 : 1'b0, 1'b0, 32'h0);
        if (len >= MAXW) begin
          req_r[p[1:0]] = 1'b0;
        end else begin
          req_r[p[1:0]] = 1'($urandom_range(0, 1));
        end
      end
    end

    // Reset in the middle of a port 0 packet.
    reset = 1'b0;
    req_r = '0;
    tick();
    reset = 1'b1;
    lw    = NP - 1;
    req_r = 4'b0001;
    wait_grant(p);
    start_r[0] = 1'b1;
    data_r[0 +: DW] = 32'h1111_0001;
    tick();
    chk("rst_word1_start", out_start, 1);
    start_r[0] = 1'b0;
    data_r[0 +: DW] = 32'h1111_0002;
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    tick();
    chk("mid_reset_no_end", out_end, 0);
    data_r = '0;
    req_r  = 4'b1111;
    reset  = 1'b1;
    lw     = NP - 1;
    wait_grant(p);
    chk("post_reset_port0", p, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xbar_port_arbiter.md
XBAR_PORT_ARBITER -- requirements
Module: xbar_port_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of input ports sharing one crossbar output.
REQ-002 SHALL have parameter DATA_W, default 32, crossbar word width.
REQ-003 SHALL have parameter MAX_WORDS, default 400, watchdog limit in words per packet (covers a 1518-byte frame at 32 bits).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, N_PORTS, per-port packet pending, held until that port's end_pack.
REQ-007 SHALL have port iba2xbar_start_pack, input, N_PORTS, per-port first-word strobe.
REQ-008 SHALL have port iba2xbar_end_pack, input, N_PORTS, per-port last-word strobe.
REQ-009 SHALL have port iba2xbar_data, input, N_PORTS*DATA_W, per-port data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port plu_ready, input, 1, downstream can accept a new packet; sampled only in IDLE.
REQ-011 SHALL have port grant, output, N_PORTS, one-hot or zero.
REQ-012 SHALL have port xbar2plu_data, output, DATA_W, muxed data.
REQ-013 SHALL have ports xbar2plu_start_pack and xbar2plu_end_pack, outputs, 1 each, muxed strobes.
REQ-014 SHALL have port err_timeout, output, 1, one-cycle watchdog pulse.

Function
REQ-015 FSM SHALL have three states: IDLE, GRANT and XFER.
REQ-016 IDLE: with req nonzero and plu_ready=1, winner SHALL be the first requesting port in round-robin order starting at last_winner+1 mod N_PORTS; grant is registered and the FSM moves to GRANT.
REQ-017 GRANT: iba2xbar_start_pack[winner]=1 SHALL move the FSM to XFER; req[winner]=0 SHALL clear grant and return to IDLE.
REQ-018 XFER: iba2xbar_end_pack[winner]=1 SHALL clear grant on the next edge and return to IDLE.
REQ-019 Start and end asserted in the same cycle (single-word packet) SHALL be forwarded together, and the FSM SHALL go GRANT to IDLE directly.
REQ-020 xbar2plu_data and xbar2plu_start_pack/xbar2plu_end_pack SHALL be the winner's inputs registered, with 1-cycle latency; the strobes are 0 for non-granted ports and in IDLE.
REQ-021 last_winner SHALL update on every GRANT entry, including an aborted GRANT.
REQ-022 Word counter: cleared on GRANT entry; incremented each XFER cycle; width clog2(MAX_WORDS+1).
REQ-023 Watchdog: counter reaching MAX_WORDS in XFER without an end strobe SHALL force xbar2plu_end_pack=1, pulse err_timeout, and return to IDLE.
REQ-024 After a watchdog abort, further words from the old winner SHALL be ignored.
REQ-025 Strobes from non-granted ports SHALL be ignored in every state.
REQ-026 After IDLE is re-entered, the next grant SHALL appear no sooner than 1 cycle later (one idle cycle minimum between packets).
REQ-027 Multiple or spurious start strobes in XFER SHALL be ignored.

Reset
REQ-028 Asserting reset (low) SHALL asynchronously force the FSM to IDLE.
REQ-029 Reset SHALL force grant=0, xbar2plu_data=0, xbar2plu_start_pack=0, xbar2plu_end_pack=0, err_timeout=0 and the counter to 0.
REQ-030 Reset SHALL force last_winner=N_PORTS-1, so the first grant search starts at port 0.
REQ-031 Reset mid-packet SHALL drop the packet with no end strobe emitted.
REQ-032 Deassertion SHALL take effect at the next clk edge.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the default values of N_PORTS, DATA_W and MAX_WORDS, and a clog2 function.
REQ-034 The round-robin priority picker SHALL be a sub-module, rr_picker, combinational: inputs req and last_winner; output one-hot winner.

Verification
REQ-035 reset low then high, req=4'b0000 -> all outputs 0, FSM in IDLE.
REQ-036 req=4'b1111, plu_ready=1, each port sends a 3-word packet -> grant order 0,1,2,3,0.
REQ-037 data=32'hA5A5_0001..0003 with end on word 3 -> the same words appear with 1-cycle latency; end_pack is output 1 cycle after the input end.
REQ-038 Single-word packet on port 2 (start=end=1, data 32'hDEAD_BEEF) -> one output cycle with both strobes and that data; grant released next edge.
REQ-039 MAX_WORDS=8, port 1 sends 12 words with no end -> forced end_pack on the 8th output word, err_timeout pulses 1 cycle, port 3 is granted next.
REQ-040 reset asserted during word 2 of a port 0 packet -> outputs 0 immediately; after release, port 0 is granted first again.
